// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register latency scoreboard with MD-unit interlock; HDU_PERF_CNT_EN adds a stall cycle counter.
module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int LW       = 3,
  parameter int BR_EXTRA = 1,
  parameter int MD_LAT   = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_id,
  input  logic          flush_id,
  input  logic [AW-1:0] Rs_id,
  input  logic [AW-1:0] Rt_id,
  input  logic          use_rs_id,
  input  logic          use_rt_id,
  input  logic          early_id,
  input  logic          RegWrite_id,
  input  logic [AW-1:0] RD_id,
  input  logic [LW-1:0] lat_id,
  input  logic          md_id,
  output logic          stall_o,
  output logic          PC_IFWrite_o,
  output logic          md_busy_o,
  output logic [31:0]   stall_cnt_o
);
  localparam logic [LW:0]   BRX  = (LW+1)'(BR_EXTRA);
  localparam logic [LW:0]   ONE  = (LW+1)'(1);
  localparam logic [LW-1:0] MDL  = LW'(MD_LAT);
  localparam logic [LW-1:0] MDL1 = LW'(MD_LAT + 1);
  logic [LW-1:0] cnt [NREG];
  logic [LW-1:0] md_cnt;
  logic [LW:0]   sum_rs, sum_rt;
  logic          haz_rs, haz_rt, haz_md, issue;
  // Sums are one bit wider so a full counter plus BR_EXTRA cannot wrap to "ready".
  always_comb begin
    sum_rs = {1'b0, cnt[Rs_id]} + (early_id ? BRX : '0);
    sum_rt = {1'b0, cnt[Rt_id]} + (early_id ? BRX : '0);
    haz_rs = use_rs_id && Rs_id != '0 && sum_rs > ONE;
    haz_rt = use_rt_id && Rt_id != '0 && sum_rt > ONE;
    haz_md = md_id && md_cnt != '0;
    stall_o = valid_id && !flush_id && (haz_rs || haz_rt || haz_md);
    issue = valid_id && !flush_id && !stall_o;
  end
  assign PC_IFWrite_o = !stall_o;
  assign md_busy_o    = md_cnt != '0;
  // Counters keep draining during stalls; a new write to the same register overrides the decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      md_cnt <= '0;
    end else begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= (r != 0 && issue && RegWrite_id && RD_id == AW'(r)) ? (md_id ? MDL1 : lat_id) :
                  (cnt[r] != '0 ? cnt[r] - 1'b1 : '0);
      md_cnt <= (issue && md_id) ? MDL : (md_cnt != '0 ? md_cnt - 1'b1 : '0);
    end
  end
`ifdef HDU_PERF_CNT_EN
  logic [31:0] stall_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (stall_o && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end
  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed instruction sequences with a queue of expected stall decisions checked by a monitor.
module tb_hazard_scoreboard;
  logic        clk = 0, rst = 1;
  logic        valid_id = 0, flush_id = 0, use_rs_id = 0, use_rt_id = 0, early_id = 0;
  logic        RegWrite_id = 0, md_id = 0;
  logic [4:0]  Rs_id = 0, Rt_id = 0, RD_id = 0;
  logic [2:0]  lat_id = 0;
  logic        stall_o, PC_IFWrite_o, md_busy_o;
  logic [31:0] stall_cnt_o;
  typedef struct packed { logic stall; logic mdchk; } exp_t;
  exp_t exp_q [$];
  int vecs = 0, errs = 0, total = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .valid_id(valid_id), .flush_id(flush_id),
    .Rs_id(Rs_id), .Rt_id(Rt_id), .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
    .early_id(early_id), .RegWrite_id(RegWrite_id), .RD_id(RD_id), .lat_id(lat_id),
    .md_id(md_id), .stall_o(stall_o), .PC_IFWrite_o(PC_IFWrite_o),
    .md_busy_o(md_busy_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (valid_id) begin
        if (exp_q.size() == 0) chk("queue_underflow", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("stall", 32'(stall_o), 32'(e.stall));
          chk("pc_ifwrite", 32'(PC_IFWrite_o), 32'(!e.stall));
          if (e.mdchk) chk("md_busy", 32'(md_busy_o), 32'(e.stall));
        end
      end else chk("idle_stall", 32'(stall_o), 0);
    end
  end

  task automatic drive(input logic [4:0] rs, rt, input logic ur, ut, early, rw,
                       input logic [4:0] rd, input logic [2:0] lat, input logic md, fl);
    valid_id = 1; Rs_id = rs; Rt_id = rt; use_rs_id = ur; use_rt_id = ut; early_id = early;
    RegWrite_id = rw; RD_id = rd; lat_id = lat; md_id = md; flush_id = fl;
  endtask

  task automatic send(input logic [4:0] rs, rt, input logic ur, ut, early, rw,
                      input logic [4:0] rd, input logic [2:0] lat, input logic md, fl,
                      input int ns, input logic mdchk);
    drive(rs, rt, ur, ut, early, rw, rd, lat, md, fl);
    for (int i = 0; i <= ns; i++) begin
      exp_q.push_back('{stall: (i < ns), mdchk: mdchk});
      @(posedge clk); #1;
    end
    total += ns;
    valid_id = 0; flush_id = 0;
  endtask

  task automatic idle(input int n);
    valid_id = 0; flush_id = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1;
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_pc", 32'(PC_IFWrite_o), 1);
    chk("rst_md_busy", 32'(md_busy_o), 0);
    chk("rst_stall_cnt", stall_cnt_o, 0);
    @(posedge clk); #1; rst = 0;
    idle(2);
    // load r5, consumer stalls, reset lands mid-stall
    send(0, 0, 0, 0, 0, 1, 5, 2, 0, 0, 0, 0);
    drive(5, 0, 1, 0, 0, 1, 2, 1, 0, 0);
    exp_q.push_back('{stall: 1, mdchk: 0});
    @(negedge clk); #1;
    rst = 1; #1;
    chk("midrst_stall", 32'(stall_o), 0);
    chk("midrst_pc", 32'(PC_IFWrite_o), 1);
    chk("midrst_md_busy", 32'(md_busy_o), 0);
    chk("midrst_stall_cnt", stall_cnt_o, 0);
    valid_id = 0;
    @(posedge clk); #1; rst = 0; total = 0;
    send(5, 0, 1, 0, 0, 1, 2, 1, 0, 0, 0, 0);
    idle(8);
    // ALU then normal consumer; load then normal consumer
    send(0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 0);
    send(3, 0, 1, 0, 0, 1, 2, 1, 0, 0, 0, 0);
    idle(8);
    send(0, 0, 0, 0, 0, 1, 3, 2, 0, 0, 0, 0);
    send(3, 0, 1, 0, 0, 1, 2, 1, 0, 0, 1, 0);
    idle(8);
    // branch consumers: ALU->beq, load->beq, load->jr
    send(0, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0);
    send(4, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    idle(8);
    send(0, 0, 0, 0, 0, 1, 4, 2, 0, 0, 0, 0);
    send(4, 0, 1, 1, 1, 0, 0, 0, 0, 0, 2, 0);
    idle(8);
    send(0, 0, 0, 0, 0, 1, 4, 2, 0, 0, 0, 0);
    send(4, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2, 0);
    idle(8);
    // MD: mult then mult (structural), mult then reader of its result
    send(10, 11, 1, 1, 0, 1, 8, 0, 1, 0, 0, 0);
    send(10, 11, 1, 1, 0, 0, 0, 0, 1, 0, 6, 1);
    idle(8);
    send(10, 11, 1, 1, 0, 1, 8, 0, 1, 0, 0, 0);
    send(8, 0, 1, 0, 0, 1, 2, 1, 0, 0, 6, 0);
    idle(8);
    // zero register is never tracked
    send(0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0);
    send(0, 0, 1, 1, 0, 1, 2, 1, 0, 0, 0, 0);
    idle(8);
    // flushed consumer never stalls; flushed producer never writes
    send(0, 0, 0, 0, 0, 1, 9, 2, 0, 0, 0, 0);
    send(9, 0, 1, 0, 0, 1, 2, 1, 0, 1, 0, 0);
    send(9, 0, 1, 0, 0, 1, 2, 1, 0, 0, 0, 0);
    idle(8);
    send(0, 0, 0, 0, 0, 1, 7, 2, 0, 1, 0, 0);
    send(7, 0, 1, 0, 0, 1, 2, 1, 0, 0, 0, 0);
    idle(8);
    // WAW: long producer overwritten by an ALU write to the same register
    send(0, 0, 0, 0, 0, 1, 6, 7, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0, 0);
    send(6, 0, 1, 0, 0, 1, 2, 1, 0, 0, 0, 0);
    idle(8);
    // zero latency never hazards, even for a branch
    send(0, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0, 0);
    send(12, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(8);
    // max latency with branch extra must not wrap: 7 stalls
    send(0, 0, 0, 0, 0, 1, 13, 7, 0, 0, 0, 0);
    send(0, 13, 0, 1, 1, 0, 0, 0, 0, 0, 7, 0);
    idle(8);
`ifdef HDU_PERF_CNT_EN
    chk("stall_cnt", stall_cnt_o, 32'(total));
`else
    chk("stall_cnt", stall_cnt_o, 0);
`endif
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
